// File: rtl/vga_frame_tx.sv
// VGA frame transmitter: bus-programmable background colour and a 32x32 box,
// rendered at one pixel every second clock. Rendering works from shadow copies
// of the colour/position registers, refreshed once per frame, so that bus
// writes never tear the image mid-frame. Raster geometry defaults to 640x480@60.
module vga_frame_tx #(
    parameter int H_ACTIVE     = 640,
    parameter int H_SYNC_START = 656,
    parameter int H_SYNC_END   = 751,
    parameter int H_TOTAL      = 800,
    parameter int V_ACTIVE     = 480,
    parameter int V_SYNC_START = 490,
    parameter int V_SYNC_END   = 491,
    parameter int V_TOTAL      = 525
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [7:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic        VGA_BLANK_n,
    output logic        frame_irq
);
    localparam logic [9:0]  H_ACT_W  = 10'(H_ACTIVE);
    localparam logic [9:0]  H_SS_W   = 10'(H_SYNC_START);
    localparam logic [9:0]  H_SE_W   = 10'(H_SYNC_END);
    localparam logic [9:0]  H_LAST_W = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_ACT_W  = 10'(V_ACTIVE);
    localparam logic [9:0]  V_SS_W   = 10'(V_SYNC_START);
    localparam logic [9:0]  V_SE_W   = 10'(V_SYNC_END);
    localparam logic [9:0]  V_LAST_W = 10'(V_TOTAL - 1);
    localparam logic [10:0] BOX_SIZE = 11'd32;

    // Live registers (bus side) and their per-frame shadows (render side)
    logic        enable_reg;
    logic [23:0] bg_color_reg, box_color_reg;
    logic [9:0]  box_x_reg, box_y_reg;
    logic [23:0] bg_sh_reg, box_color_sh_reg;
    logic [9:0]  box_x_sh_reg, box_y_sh_reg;

    logic        pix_en_reg;
    logic [9:0]  hcount_reg, vcount_reg;
    logic [15:0] frame_count_reg;
    logic        frame_irq_reg;
    logic [31:0] readdata_reg;
    logic        hsync_reg, vsync_reg, blank_n_reg;
    logic [23:0] rgb_bus;

    logic        bus_wr, bus_rd, ctrl_wr, run, start, frame_end;
    logic        visible, in_box;
    logic [10:0] h_ext, v_ext, bx_ext, by_ext;
    logic [23:0] pixel_color;
    logic        unused_writedata;

    assign bus_wr  = chipselect && write;
    assign bus_rd  = chipselect && read;
    assign ctrl_wr = bus_wr && (address == 8'd0);
    // Raster runs this cycle only if enabled and not being disabled right now,
    // so clearing enable takes effect at the very next clock edge.
    assign run     = enable_reg && !(ctrl_wr && !writedata[0]);
    assign start   = ctrl_wr && writedata[0] && !enable_reg;
    assign frame_end = run && pix_en_reg && (hcount_reg == H_LAST_W) && (vcount_reg == V_LAST_W);
    assign unused_writedata = &{writedata[31:26], writedata[15:10]};

    // Bus write port for the live registers; STATUS and unmapped addresses ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            enable_reg    <= 1'b0;
            bg_color_reg  <= '0;
            box_x_reg     <= '0;
            box_y_reg     <= '0;
            box_color_reg <= '0;
        end else if (bus_wr) begin
            case (address)
                8'd0: enable_reg    <= writedata[0];
                8'd1: bg_color_reg  <= writedata[23:0];
                8'd2: begin
                    box_x_reg <= writedata[9:0];
                    box_y_reg <= writedata[25:16];
                end
                8'd3: box_color_reg <= writedata[23:0];
                default: ;
            endcase
        end
    end

    // Shadow load at enable rise and at the last pixel of every frame
    always_ff @(posedge clk) begin
        if (reset) begin
            bg_sh_reg        <= '0;
            box_x_sh_reg     <= '0;
            box_y_sh_reg     <= '0;
            box_color_sh_reg <= '0;
        end else if (start || frame_end) begin
            bg_sh_reg        <= bg_color_reg;
            box_x_sh_reg     <= box_x_reg;
            box_y_sh_reg     <= box_y_reg;
            box_color_sh_reg <= box_color_reg;
        end
    end

    // Pixel-rate enable and raster counters, parked at 0 while not running
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            pix_en_reg <= 1'b0;
            hcount_reg <= '0;
            vcount_reg <= '0;
        end else begin
            pix_en_reg <= ~pix_en_reg;
            if (pix_en_reg) begin
                if (hcount_reg == H_LAST_W) begin
                    hcount_reg <= '0;
                    vcount_reg <= (vcount_reg == V_LAST_W) ? 10'd0 : vcount_reg + 10'd1;
                end else begin
                    hcount_reg <= hcount_reg + 10'd1;
                end
            end
        end
    end

    // End-of-frame pulse and frame counter
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_irq_reg   <= 1'b0;
            frame_count_reg <= '0;
        end else begin
            frame_irq_reg <= frame_end;
            if (frame_end)
                frame_count_reg <= frame_count_reg + 16'd1;
        end
    end

    // Pixel colour from the current counters; box edges computed in 11 bits so they never wrap
    always_comb begin
        h_ext   = {1'b0, hcount_reg};
        v_ext   = {1'b0, vcount_reg};
        bx_ext  = {1'b0, box_x_sh_reg};
        by_ext  = {1'b0, box_y_sh_reg};
        visible = (hcount_reg < H_ACT_W) && (vcount_reg < V_ACT_W);
        in_box  = (h_ext >= bx_ext) && (h_ext < bx_ext + BOX_SIZE) &&
                  (v_ext >= by_ext) && (v_ext < by_ext + BOX_SIZE);
        pixel_color = '0;
        if (visible)
            pixel_color = in_box ? box_color_sh_reg : bg_sh_reg;
    end

    // Sync and blank registered on pix_en cycles, aligned with RGB below
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            hsync_reg   <= 1'b1;
            vsync_reg   <= 1'b1;
            blank_n_reg <= 1'b0;
        end else if (pix_en_reg) begin
            hsync_reg   <= !((hcount_reg >= H_SS_W) && (hcount_reg <= H_SE_W));
            vsync_reg   <= !((vcount_reg >= V_SS_W) && (vcount_reg <= V_SE_W));
            blank_n_reg <= visible;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_rgb
            logic [7:0] chan_reg;
            // One colour channel of the pixel pipeline
            always_ff @(posedge clk) begin
                if (reset || !run)
                    chan_reg <= '0;
                else if (pix_en_reg)
                    chan_reg <= pixel_color[gi*8 +: 8];
            end
            assign rgb_bus[gi*8 +: 8] = chan_reg;
        end
    endgenerate

    // Registered read port; reads see register state before any same-cycle write
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_reg <= '0;
        end else if (bus_rd) begin
            case (address)
                8'd0:    readdata_reg <= {31'd0, enable_reg};
                8'd1:    readdata_reg <= {8'd0, bg_color_reg};
                8'd2:    readdata_reg <= {6'd0, box_y_reg, 6'd0, box_x_reg};
                8'd3:    readdata_reg <= {8'd0, box_color_reg};
                8'd4:    readdata_reg <= {frame_count_reg, 6'd0, vcount_reg};
                default: readdata_reg <= '0;
            endcase
        end
    end

    assign readdata    = readdata_reg;
    assign VGA_R       = rgb_bus[23:16];
    assign VGA_G       = rgb_bus[15:8];
    assign VGA_B       = rgb_bus[7:0];
    assign HSYNC       = hsync_reg;
    assign VSYNC       = vsync_reg;
    assign VGA_BLANK_n = blank_n_reg;
    assign frame_irq   = frame_irq_reg;

endmodule

// File: tb/tb_vga_frame_tx.sv
// Directed bench for vga_frame_tx on a reduced raster (60x45 total, 48x40
// visible) so that several complete frames fit in a short run.
module tb_vga_frame_tx;
    localparam int HA = 48, HSS = 52, HSE = 55, HT = 60;
    localparam int VA = 40, VSS = 42, VSE = 43, VT = 45;
    localparam int NPIX = HT * VT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        chipselect = 1'b0, write = 1'b0, read = 1'b0;
    logic [7:0]  address = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        HSYNC, VSYNC, VGA_BLANK_n, frame_irq;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int e0 = 0;
    int irq_total = 0;
    int irq_cyc[$];
    logic [7:0]  wr_addr[4];
    logic [31:0] wr_data[4];

    vga_frame_tx #(
        .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT)
    ) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
        .read(read), .address(address), .writedata(writedata),
        .readdata(readdata), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .VGA_BLANK_n(VGA_BLANK_n),
        .frame_irq(frame_irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_irq === 1'b1) begin
            irq_total <= irq_total + 1;
            irq_cyc.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached at cycle %0d, required run to complete", cyc);
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int target);
        if (cyc > target) begin
            n_checks++;
            n_fail++;
            $display("FAIL schedule: at cycle %0d, required cycle %0d", cyc, target);
        end
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write = 1'b0;
        $display("write addr %0d data %08h at cycle %0d", a, d, cyc);
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(posedge clk);
        #1;
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
        $display("read  addr %0d data %08h at cycle %0d", a, d, cyc);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({HSYNC, VSYNC, VGA_BLANK_n, frame_irq} !== 4'b1100) begin
            n_fail++;
            $display("FAIL reset_ctrl: got hs/vs/blank/irq %b, want 1100", {HSYNC, VSYNC, VGA_BLANK_n, frame_irq});
        end
        n_checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_rgb: got %06h, want 000000", {VGA_R, VGA_G, VGA_B});
        end
        n_checks++;
        if (readdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_readdata: got %08h, want 00000000", readdata);
        end
        n_checks++;
        if (irq_total !== 0) begin
            n_fail++;
            $display("FAIL reset_irq: got %0d pulses, want 0", irq_total);
        end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        bus_write(8'd1, 32'h0000_00FF);
        bus_read(8'd1, d);
        n_checks++;
        if (d !== 32'h0000_00FF) begin n_fail++; $display("FAIL bg_readback: got %08h, want 000000ff", d); end
        bus_read(8'd7, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %08h, want 00000000", d); end
        bus_write(8'd4, 32'hFFFF_FFFF);
        bus_read(8'd4, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL status_write_ignored: got %08h, want 00000000", d); end
        // Simultaneous read and write of BOX_COLOR returns the old value
        chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 8'd3; writedata = 32'h00AB_CDEF;
        @(posedge clk);
        #1;
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        $display("rd+wr addr 3 data 00abcdef, read %08h at cycle %0d", readdata, cyc);
        n_checks++;
        if (readdata !== 32'h0) begin n_fail++; $display("FAIL rw_same_cycle: got %08h, want 00000000", readdata); end
        bus_read(8'd3, d);
        n_checks++;
        if (d !== 32'h00AB_CDEF) begin n_fail++; $display("FAIL rw_new_value: got %08h, want 00abcdef", d); end
        bus_write(8'd2, 32'h03E8_03E8);
        bus_read(8'd2, d);
        n_checks++;
        if (d !== 32'h03E8_03E8) begin n_fail++; $display("FAIL boxpos_readback: got %08h, want 03e803e8", d); end
    endtask

    // Checks every pixel of frame f against the expected image; wr_n bus writes
    // from wr_addr/wr_data are issued at the start of line 20 of this frame.
    task automatic scan_frame(input int f, input logic [23:0] bg, input int bx, input int by,
                              input logic [23:0] bc, input int wr_n, input string tag);
        int bad_hs, bad_vs, bad_bl, bad_rgb, vis, hs_low, irq0, t, t_irq;
        logic exp_hs, exp_vs, exp_bl;
        logic [23:0] exp_rgb, act_rgb;
        string first_msg;
        bad_hs = 0; bad_vs = 0; bad_bl = 0; bad_rgb = 0; vis = 0; hs_low = 0; t = 0;
        first_msg = "";
        irq0 = irq_total;
        for (int v = 0; v < VT; v++) begin
            for (int h = 0; h < HT; h++) begin
                t = e0 + 2 + 2 * (f * NPIX + v * HT + h);
                wait_cyc(t);
                exp_hs = (h >= HSS && h <= HSE) ? 1'b0 : 1'b1;
                exp_vs = (v >= VSS && v <= VSE) ? 1'b0 : 1'b1;
                exp_bl = (h < HA) && (v < VA);
                if (!exp_bl)
                    exp_rgb = 24'h0;
                else if (h >= bx && h < bx + 32 && v >= by && v < by + 32)
                    exp_rgb = bc;
                else
                    exp_rgb = bg;
                act_rgb = {VGA_R, VGA_G, VGA_B};
                if (HSYNC !== exp_hs) bad_hs++;
                if (VSYNC !== exp_vs) bad_vs++;
                if (VGA_BLANK_n !== exp_bl) bad_bl++;
                if (act_rgb !== exp_rgb) begin
                    if (bad_rgb == 0)
                        first_msg = $sformatf("first at (%0d,%0d) got %06h want %06h", h, v, act_rgb, exp_rgb);
                    bad_rgb++;
                end
                if (VGA_BLANK_n === 1'b1) vis++;
                if (HSYNC === 1'b0) hs_low++;
                if (v == 20 && h < wr_n) bus_write(wr_addr[h], wr_data[h]);
            end
        end
        wait_cyc(t + 1);
        $display("%s frame %0d: visible %0d, hsync-low %0d, rgb errors %0d", tag, f, vis, hs_low, bad_rgb);
        n_checks++;
        if (bad_rgb != 0) begin n_fail++; $display("FAIL %s_rgb: %0d bad pixels, %s", tag, bad_rgb, first_msg); end
        n_checks++;
        if (bad_hs != 0) begin n_fail++; $display("FAIL %s_hsync: %0d bad pixels, want 0", tag, bad_hs); end
        n_checks++;
        if (bad_vs != 0) begin n_fail++; $display("FAIL %s_vsync: %0d bad pixels, want 0", tag, bad_vs); end
        n_checks++;
        if (bad_bl != 0) begin n_fail++; $display("FAIL %s_blank: %0d bad pixels, want 0", tag, bad_bl); end
        n_checks++;
        if (vis != HA * VA) begin n_fail++; $display("FAIL %s_visible_count: got %0d, want %0d", tag, vis, HA * VA); end
        n_checks++;
        if (hs_low != (HSE - HSS + 1) * VT) begin n_fail++; $display("FAIL %s_hsync_count: got %0d, want %0d", tag, hs_low, (HSE - HSS + 1) * VT); end
        t_irq = e0 + 2 + 2 * (f * NPIX + NPIX - 1);
        n_checks++;
        if ((irq_total - irq0) != 1 || irq_cyc[irq_cyc.size() - 1] != t_irq) begin
            n_fail++;
            $display("FAIL %s_irq: got %0d pulses last at cycle %0d, want 1 at cycle %0d",
                     tag, irq_total - irq0, (irq_cyc.size() > 0) ? irq_cyc[irq_cyc.size() - 1] : -1, t_irq);
        end
    endtask

    task automatic test_frames();
        bus_write(8'd0, 32'h1);
        e0 = cyc;
        // Frame 0: background only; new box programmed mid-frame must not show yet
        wr_addr[0] = 8'd2; wr_data[0] = 32'h0005_000A;
        wr_addr[1] = 8'd3; wr_data[1] = 32'h00FF_0000;
        scan_frame(0, 24'h0000FF, 1000, 1000, 24'h0, 2, "bg_frame");
        // Frame 1: red box at (10,5); recolour and move to the clipping position mid-frame
        wr_addr[0] = 8'd3; wr_data[0] = 32'h0000_FF00;
        wr_addr[1] = 8'd2; wr_data[1] = 32'h0000_0028;
        scan_frame(1, 24'h0000FF, 10, 5, 24'hFF0000, 2, "box_frame");
        n_checks++;
        if (irq_cyc.size() < 2 || (irq_cyc[1] - irq_cyc[0]) != 2 * NPIX) begin
            n_fail++;
            $display("FAIL frame_period: got %0d clk, want %0d", (irq_cyc.size() < 2) ? -1 : irq_cyc[1] - irq_cyc[0], 2 * NPIX);
        end
        // Frame 2: green box at x=40 clipped at the right edge of the visible area
        scan_frame(2, 24'h0000FF, 40, 0, 24'h00FF00, 0, "clip_frame");
    endtask

    task automatic test_status_and_reset();
        logic [31:0] d;
        wait_cyc(e0 + 2 + 2 * (3 * NPIX + 10 * HT));
        bus_read(8'd4, d);
        n_checks++;
        if (d !== 32'h0003_000A) begin n_fail++; $display("FAIL status_line10_frame3: got %08h, want 0003000a", d); end
        wait_cyc(e0 + 2 + 2 * (3 * NPIX + 20 * HT + 30));
        n_checks++;
        if ({VGA_BLANK_n, VGA_R, VGA_G, VGA_B} !== 25'h1_0000FF) begin
            n_fail++;
            $display("FAIL pre_reset_pixel: got blank %b rgb %06h, want 1 0000ff", VGA_BLANK_n, {VGA_R, VGA_G, VGA_B});
        end
        // Reset with a competing BG write in the same cycle
        reset = 1'b1; chipselect = 1'b1; write = 1'b1; address = 8'd1; writedata = 32'h0012_3456;
        @(posedge clk);
        #1;
        reset = 1'b0; chipselect = 1'b0; write = 1'b0;
        $display("reset mid-frame at cycle %0d", cyc);
        n_checks++;
        if ({HSYNC, VSYNC, VGA_BLANK_n, frame_irq, VGA_R, VGA_G, VGA_B, readdata} !== {4'b1100, 24'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL midframe_reset_outputs: got hs %b vs %b bl %b irq %b rgb %06h rd %08h, want 1 1 0 0 000000 00000000",
                     HSYNC, VSYNC, VGA_BLANK_n, frame_irq, {VGA_R, VGA_G, VGA_B}, readdata);
        end
        bus_read(8'd1, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_beats_write: got %08h, want 00000000", d); end
        bus_read(8'd4, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL status_after_reset: got %08h, want 00000000", d); end
    endtask

    task automatic test_reenable_and_disable();
        logic [31:0] d;
        int irq0;
        irq0 = irq_total;
        bus_write(8'd0, 32'h1);
        e0 = cyc;
        wait_cyc(e0 + 2 + 2 * NPIX);
        bus_read(8'd4, d);
        n_checks++;
        if (d !== 32'h0001_0000) begin n_fail++; $display("FAIL frame_count_restart: got %08h, want 00010000", d); end
        n_checks++;
        if (irq_total - irq0 != 1) begin n_fail++; $display("FAIL irq_after_reenable: got %0d, want 1", irq_total - irq0); end
        wait_cyc(e0 + 2 + 2 * (NPIX + 5 * HT + 5));
        n_checks++;
        if (VGA_BLANK_n !== 1'b1) begin n_fail++; $display("FAIL visible_before_disable: got %b, want 1", VGA_BLANK_n); end
        bus_write(8'd0, 32'h0);
        n_checks++;
        if ({HSYNC, VSYNC, VGA_BLANK_n, VGA_R, VGA_G, VGA_B} !== {3'b110, 24'h0}) begin
            n_fail++;
            $display("FAIL disable_next_clk: got hs %b vs %b bl %b rgb %06h, want 1 1 0 000000",
                     HSYNC, VSYNC, VGA_BLANK_n, {VGA_R, VGA_G, VGA_B});
        end
        irq0 = irq_total;
        repeat (200) @(posedge clk);
        #1;
        bus_read(8'd4, d);
        n_checks++;
        if (d !== 32'h0001_0000) begin n_fail++; $display("FAIL status_disabled: got %08h, want 00010000", d); end
        n_checks++;
        if (irq_total != irq0) begin n_fail++; $display("FAIL irq_while_disabled: got %0d, want 0", irq_total - irq0); end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_frames();
        test_status_and_reset();
        test_reenable_and_disable();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
